// File: rtl/dmux_stream_pkg.sv
// Shared defaults and helpers for the dmux_stream word demultiplexer.
// Select width is derived from the channel count when not given explicitly.
package dmux_stream_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_N     = 8;
    localparam int DEF_CNT_W = 8;

    // Select width: ceil(log2(n)), never below one bit.
    function automatic int sel_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/dmux_chan_reg.sv
// One-entry output register for a single dmux_stream channel.
// A load wins over a same-cycle drain, so the channel can refill while emptying.
module dmux_chan_reg
    import dmux_stream_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             out_ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (valid_q && out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/dmux_stream.sv
// Registered 1-to-N valid/ready demultiplexer with broadcast mode and a
// saturating counter of words dropped for an out-of-range select.
module dmux_stream
    import dmux_stream_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = DEF_N,
    parameter int SEL_W = sel_width(N),
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic               in_bcast,
    output logic [N-1:0]       out_valid,
    input  logic [N-1:0]       out_ready,
    output logic [N*WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]   drop_cnt
);

    localparam logic [SEL_W:0] N_EXT = (SEL_W + 1)'(N);

    logic [N-1:0]     chan_free;
    logic [N-1:0]     sel_onehot;
    logic [N-1:0]     load_vec;
    logic             sel_in_range;
    logic             accept;
    logic [CNT_W-1:0] drop_q, drop_d;

    assign chan_free    = ~out_valid | out_ready;
    assign sel_in_range = ({1'b0, in_sel} < N_EXT);

    always_comb begin
        sel_onehot = '0;
        for (int i = 0; i < N; i++) begin
            sel_onehot[i] = (in_sel == SEL_W'(i));
        end
    end

    // Out-of-range unicast words are always taken so the producer never stalls on them.
    always_comb begin
        in_ready = 1'b0;
        if (!reset) begin
            if (in_bcast) begin
                in_ready = &chan_free;
            end else if (sel_in_range) begin
                in_ready = |(chan_free & sel_onehot);
            end else begin
                in_ready = 1'b1;
            end
        end
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        load_vec = '0;
        if (accept) begin
            load_vec = in_bcast ? {N{1'b1}} : sel_onehot;
        end
    end

    always_comb begin
        drop_d = drop_q;
        if (accept && !in_bcast && !sel_in_range && (drop_q != {CNT_W{1'b1}})) begin
            drop_d = drop_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_cnt = drop_q;

    for (genvar g = 0; g < N; g++) begin : g_chan
        dmux_chan_reg #(
            .WIDTH(WIDTH)
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .load_i     (load_vec[g]),
            .data_i     (in_data),
            .out_ready_i(out_ready[g]),
            .valid_o    (out_valid[g]),
            .data_o     (out_data[g*WIDTH +: WIDTH])
        );
    end

endmodule
